haar_stage_sequencer: RTL and testbench

Multi-stage successor to the single-stage classifier database reader. It streams every classifier parameter word, then every stage-threshold word, for `NUM_STAGES` cascade stages from one on-chip ROM image. Each word leaves with its stage, tree and parameter indices over a valid/ready handshake. It sits between the classifier ROM image and the Haar feature evaluator, and supports early abort when a stage rejects a window.

---
 rtl/haar_stage_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_haar_stage_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/haar_stage_sequencer.sv
// Streams every classifier parameter word and stage-threshold word of a multi-stage
// Haar cascade from a single ROM image, tagging each word with stage/tree/param indices.
module haar_stage_sequencer #(
  parameter int    ADDR_WIDTH               = 10,
  parameter int    DATA_WIDTH               = 12,
  parameter int    STAGE_WIDTH              = 4,
  parameter int    NUM_STAGES               = 4,
  parameter int    NUM_CLASSIFIERS_STAGE    = 10,
  parameter int    NUM_PARAM_PER_CLASSIFIER = 19,
  parameter int    NUM_STAGE_THRESHOLD      = 3,
  parameter string FILE_STAGE_MEM           = "memory.mif",
  parameter int    ROM_FILL_BASE            = 0
) (
  input  logic                   clk_fpga,
  input  logic                   reset_fpga,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic [STAGE_WIDTH-1:0] o_stage_index,
  output logic [ADDR_WIDTH-1:0]  o_tree_index,
  output logic [ADDR_WIDTH-1:0]  o_param_index,
  output logic                   o_is_threshold,
  output logic                   o_last_tree,
  output logic                   o_last_stage_word,
  output logic                   o_done,
  output logic                   o_busy
);

  localparam int STAGE_WORDS = NUM_CLASSIFIERS_STAGE * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;
  localparam int DEPTH       = NUM_STAGES * STAGE_WORDS;
  localparam int ROM_SLOTS   = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0]  LAST_PARAM = ADDR_WIDTH'(NUM_PARAM_PER_CLASSIFIER - 1);
  localparam logic [ADDR_WIDTH-1:0]  LAST_TREE  = ADDR_WIDTH'(NUM_CLASSIFIERS_STAGE - 1);
  localparam logic [ADDR_WIDTH-1:0]  LAST_THR   = ADDR_WIDTH'(NUM_STAGE_THRESHOLD - 1);
  localparam logic [STAGE_WIDTH-1:0] LAST_STAGE = STAGE_WIDTH'(NUM_STAGES - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [STAGE_WIDTH-1:0] stage;
    logic [ADDR_WIDTH-1:0]  tree;
    logic [ADDR_WIDTH-1:0]  param;
    logic                   is_thr;
    logic                   last_tree;
    logic                   last_stage_word;
  } tag_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    tag_t                  tag;
  } word_t;

  typedef logic [ROM_SLOTS-1:0][DATA_WIDTH-1:0] rom_image_t;

  // Ramp fill defines the ROM image.
  function automatic rom_image_t load_rom();
    logic [DATA_WIDTH-1:0] img [ROM_SLOTS];
    rom_image_t            flat;
    for (int i = 0; i < ROM_SLOTS; i++)
      img[i] = (i < DEPTH) ? DATA_WIDTH'(ROM_FILL_BASE + i) : '0;
    for (int i = 0; i < ROM_SLOTS; i++)
      flat[i] = img[i];
    return flat;
  endfunction

  rom_image_t rom_mem = load_rom();

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]  param_q, param_d;
  logic [ADDR_WIDTH-1:0]  tree_q, tree_d;
  logic [STAGE_WIDTH-1:0] stage_q, stage_d;
  logic                   in_thr_q, in_thr_d;
  logic                   rd_valid_q, rd_valid_d;
  tag_t                   rd_tag_q, rd_tag_d;
  logic [DATA_WIDTH-1:0]  rom_q, rom_d;
  word_t [1:0]            buf_q, buf_d;
  logic                   wr_ptr_q, wr_ptr_d;
  logic                   rd_ptr_q, rd_ptr_d;
  logic [1:0]             count_q, count_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  logic       pop;
  logic       issue;
  logic [2:0] occ_after;
  tag_t       cur_tag;
  word_t      head;

  // Occupancy after this edge counts the pop, so a read can be issued every cycle
  // while the consumer keeps up, yet the two buffer slots can never overflow.
  always_comb begin
    pop       = (count_q != 2'd0) && i_ready;
    occ_after = 3'(count_q) + 3'(rd_valid_q) - 3'(pop);
    issue     = (state_q == S_FETCH) && !i_abort && (occ_after < 3'd2);

    cur_tag.stage           = stage_q;
    cur_tag.tree            = tree_q;
    cur_tag.param           = param_q;
    cur_tag.is_thr          = in_thr_q;
    cur_tag.last_tree       = !in_thr_q && (param_q == LAST_PARAM);
    cur_tag.last_stage_word = in_thr_q && (param_q == LAST_THR);

    state_d    = state_q;
    addr_d     = addr_q;
    param_d    = param_q;
    tree_d     = tree_q;
    stage_d    = stage_q;
    in_thr_d   = in_thr_q;
    rd_valid_d = issue;
    rd_tag_d   = rd_tag_q;
    rom_d      = rom_q;
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = occ_after[1:0];

    if (issue) begin
      rom_d    = rom_mem[addr_q];
      rd_tag_d = cur_tag;
      addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
      if (!in_thr_q) begin
        if (param_q == LAST_PARAM) begin
          param_d = '0;
          if (tree_q == LAST_TREE) begin
            tree_d   = '0;
            in_thr_d = 1'b1;
          end else begin
            tree_d = tree_q + 1'b1;
          end
        end else begin
          param_d = param_q + 1'b1;
        end
      end else begin
        if (param_q == LAST_THR) begin
          param_d  = '0;
          in_thr_d = 1'b0;
          stage_d  = (stage_q == LAST_STAGE) ? '0 : stage_q + 1'b1;
        end else begin
          param_d = param_q + 1'b1;
        end
      end
    end

    if (pop)
      rd_ptr_d = ~rd_ptr_q;
    if (rd_valid_q) begin
      buf_d[wr_ptr_q] = '{data: rom_q, tag: rd_tag_q};
      wr_ptr_d        = ~wr_ptr_q;
    end

    case (state_q)
      S_IDLE:  if (i_start) state_d = S_FETCH;
      S_FETCH: if (issue && addr_q == LAST_ADDR) state_d = S_DRAIN;
      S_DRAIN: if (occ_after == 3'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort throws away the buffer and the read in flight and rewinds the pass.
    if (i_abort && (state_q == S_FETCH || state_q == S_DRAIN)) begin
      state_d    = S_DONE;
      addr_d     = '0;
      param_d    = '0;
      tree_d     = '0;
      stage_d    = '0;
      in_thr_d   = 1'b0;
      rd_valid_d = 1'b0;
      count_d    = 2'd0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
    end

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      param_q    <= '0;
      tree_q     <= '0;
      stage_q    <= '0;
      in_thr_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_tag_q   <= '0;
      rom_q      <= '0;
      buf_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      param_q    <= param_d;
      tree_q     <= tree_d;
      stage_q    <= stage_d;
      in_thr_q   <= in_thr_d;
      rd_valid_q <= rd_valid_d;
      rd_tag_q   <= rd_tag_d;
      rom_q      <= rom_d;
      buf_q      <= buf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign head              = buf_q[rd_ptr_q];
  assign o_valid           = (count_q != 2'd0);
  assign o_data            = o_valid ? head.data : '0;
  assign o_stage_index     = o_valid ? head.tag.stage : '0;
  assign o_tree_index      = o_valid ? head.tag.tree : '0;
  assign o_param_index     = o_valid ? head.tag.param : '0;
  assign o_is_threshold    = o_valid && head.tag.is_thr;
  assign o_last_tree       = o_valid && head.tag.last_tree;
  assign o_last_stage_word = o_valid && head.tag.last_stage_word;
  assign o_done            = done_q;
  assign o_busy            = busy_q;

endmodule

// File: tb/tb_haar_stage_sequencer.sv
// Self-checking bench for haar_stage_sequencer: cycle table for a full pass, then
// backpressure, abort, start-while-busy, mid-pass reset and randomized ready/abort passes.
module tb_haar_stage_sequencer;

  localparam int NS    = 2;
  localparam int NC    = 2;
  localparam int NP    = 3;
  localparam int NT    = 1;
  localparam int SW    = NC * NP + NT;
  localparam int DEPTH = NS * SW;

  logic        clk_fpga = 1'b0;
  logic        reset_fpga;
  logic        i_start;
  logic        i_abort;
  logic        i_ready;
  logic        o_valid;
  logic [11:0] o_data;
  logic [3:0]  o_stage_index;
  logic [9:0]  o_tree_index;
  logic [9:0]  o_param_index;
  logic        o_is_threshold;
  logic        o_last_tree;
  logic        o_last_stage_word;
  logic        o_done;
  logic        o_busy;

  int checks = 0;
  int errors = 0;
  logic [38:0] words [$];

  typedef struct {
    logic        start;
    logic        ready;
    logic        exp_valid;
    logic [38:0] exp_word;
    logic        exp_done;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [18];

  haar_stage_sequencer #(
    .ADDR_WIDTH(10), .DATA_WIDTH(12), .STAGE_WIDTH(4),
    .NUM_STAGES(NS), .NUM_CLASSIFIERS_STAGE(NC),
    .NUM_PARAM_PER_CLASSIFIER(NP), .NUM_STAGE_THRESHOLD(NT),
    .FILE_STAGE_MEM(""), .ROM_FILL_BASE(100)
  ) dut (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga),
    .i_start(i_start), .i_abort(i_abort), .i_ready(i_ready),
    .o_valid(o_valid), .o_data(o_data), .o_stage_index(o_stage_index),
    .o_tree_index(o_tree_index), .o_param_index(o_param_index),
    .o_is_threshold(o_is_threshold), .o_last_tree(o_last_tree),
    .o_last_stage_word(o_last_stage_word), .o_done(o_done), .o_busy(o_busy)
  );

  always #5 clk_fpga = ~clk_fpga;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Word i of the linear image decoded straight from the cascade layout.
  function automatic logic [38:0] modelWord(input int i);
    int s, r, tr, p;
    logic thr, lt, lsw;
    s = i / SW;
    r = i % SW;
    if (r < NC * NP) begin
      tr = r / NP; p = r % NP; thr = 1'b0; lt = (p == NP - 1); lsw = 1'b0;
    end else begin
      tr = 0; p = r - NC * NP; thr = 1'b1; lt = 1'b0; lsw = (p == NT - 1);
    end
    return {12'(100 + i), 4'(s), 10'(tr), 10'(p), thr, lt, lsw};
  endfunction

  function automatic logic [38:0] obsWord();
    return {o_data, o_stage_index, o_tree_index, o_param_index,
            o_is_threshold, o_last_tree, o_last_stage_word};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    i_start = v.start;
    i_ready = v.ready;
    i_abort = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_outputs"}, 64'({o_valid, obsWord()}), 64'd0);
    checkOutput({name, "_done"}, 64'(o_done), 64'd0);
    checkOutput({name, "_busy"}, 64'(o_busy), 64'd0);
  endtask

  // mode 0: 1010 then 5 low then high; mode 1: random ready; other: ready high.
  task automatic streamPass(input int mode, input int abort_word, input int busy_start_word);
    int cyc, got;
    logic stalled, aborted;
    logic [39:0] snap;
    words.delete();
    got = 0; cyc = 0; aborted = 1'b0;
    i_start = 1'b1; i_ready = 1'b0; i_abort = 1'b0;
    tick();
    i_start = 1'b0;
    while (!o_done && cyc < 400) begin
      case (mode)
        0:       i_ready = (cyc < 10) ? (cyc % 2 == 0) : ((cyc < 15) ? 1'b0 : 1'b1);
        1:       i_ready = 1'($urandom_range(0, 1));
        default: i_ready = 1'b1;
      endcase
      if (mode == 0 && cyc >= 15 && cyc <= 18)
        checkOutput("no_bubble", 64'(o_valid), 64'd1);
      i_abort = (abort_word >= 0) && o_valid && i_ready && (got == abort_word);
      i_start = (busy_start_word >= 0) && o_valid && (got == busy_start_word);
      if (o_valid && i_ready) begin
        words.push_back(obsWord());
        got++;
      end
      stalled = o_valid && !i_ready;
      snap    = {o_valid, obsWord()};
      aborted = i_abort;
      tick();
      if (stalled)
        checkOutput("stall_hold", 64'({o_valid, obsWord()}), 64'(snap));
      if (aborted) begin
        checkOutput("abort_done", 64'(o_done), 64'd1);
        checkOutput("abort_valid", 64'(o_valid), 64'd0);
      end
      cyc++;
    end
    i_start = 1'b0;
    i_abort = 1'b0;
    checkOutput("done_reached", 64'(o_done), 64'd1);
    checkOutput("done_valid_low", 64'(o_valid), 64'd0);
    tick();
    checkOutput("idle_after_done", 64'({o_busy, o_done, o_valid}), 64'd0);
  endtask

  task automatic verifyWords(input string name, input int n);
    checkOutput({name, "_count"}, 64'(words.size()), 64'(n));
    for (int i = 0; i < n && i < words.size(); i++)
      checkOutput({name, "_word"}, 64'(words[i]), 64'(modelWord(i)));
  endtask

  initial begin
    int cyc, aw;

    for (int c = 0; c < 18; c++) begin
      vecs[c].start     = (c == 0);
      vecs[c].ready     = 1'b1;
      vecs[c].exp_valid = (c >= 2 && c <= 15);
      vecs[c].exp_word  = (c >= 2 && c <= 15) ? modelWord(c - 2) : 39'd0;
      vecs[c].exp_done  = (c == 16);
      vecs[c].exp_busy  = (c <= 16);
    end

    reset_fpga = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    tick();
    tick();
    checkAllZero("reset");
    reset_fpga = 1'b0;
    tick();
    checkAllZero("post_reset_idle");

    $display("[TB] full pass with ready high");
    for (int c = 0; c < 18; c++) begin
      applyStimulus(vecs[c]);
      tick();
      checkOutput("tbl_valid", 64'(o_valid), 64'(vecs[c].exp_valid));
      checkOutput("tbl_word", 64'(obsWord()), 64'(vecs[c].exp_word));
      checkOutput("tbl_done", 64'(o_done), 64'(vecs[c].exp_done));
      checkOutput("tbl_busy", 64'(o_busy), 64'(vecs[c].exp_busy));
      if (c == 8) begin
        checkOutput("w6_data", 64'(o_data), 64'd106);
        checkOutput("w6_tags", 64'({o_stage_index, o_tree_index, o_param_index}), 64'd0);
        checkOutput("w6_flags", 64'({o_is_threshold, o_last_tree, o_last_stage_word}), 64'b101);
      end
      if (c == 9)
        checkOutput("w7_tags", 64'({o_stage_index, o_tree_index, o_param_index, o_is_threshold}),
                    64'({4'd1, 10'd0, 10'd0, 1'b0}));
    end

    $display("[TB] backpressure pass");
    streamPass(0, -1, -1);
    verifyWords("bp", DEPTH);

    $display("[TB] abort on word 4");
    streamPass(2, 4, -1);
    verifyWords("abort", 5);
    streamPass(2, -1, -1);
    verifyWords("after_abort", DEPTH);

    $display("[TB] start while busy");
    streamPass(2, -1, 5);
    verifyWords("busy_start", DEPTH);

    $display("[TB] reset mid-pass");
    i_start = 1'b1; i_ready = 1'b1;
    tick();
    i_start = 1'b0;
    cyc = 0;
    while (!(o_valid && o_data == 12'd109) && cyc < 50) begin
      tick();
      cyc++;
    end
    checkOutput("reach_word9", 64'(o_data), 64'd109);
    reset_fpga = 1'b1;
    tick();
    reset_fpga = 1'b0;
    checkAllZero("mid_reset");
    tick();
    checkAllZero("mid_reset_next");
    streamPass(2, -1, -1);
    verifyWords("after_reset", DEPTH);

    $display("[TB] randomized ready");
    for (int p = 0; p < 3; p++) begin
      streamPass(1, -1, -1);
      verifyWords("rand", DEPTH);
    end
    aw = $urandom_range(0, DEPTH - 1);
    streamPass(1, aw, -1);
    verifyWords("rand_abort", aw + 1);

    $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
